// File: rtl/fm_audio_pkg.sv
// Shared types and constants for the FM receiver audio path.
// Holds the gain-stage FSM encoding and saturation bound helpers.
package fm_audio_pkg;

    localparam int FRAC_BITS_DEFAULT  = 10;
    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_WAIT,
        S_LATCH,
        S_MULT,
        S_WRITE
    } gain_state_t;

    // Bounds come back in 64 bits; callers keep the low width bits.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/gain_sat_mult.sv
// Combinational Q-format gain: multiply, arithmetic rescale, saturate.
// sat_o flags any sample that had to be clipped to MAX or MIN.
module gain_sat_mult
    import fm_audio_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int FRAC_BITS  = FRAC_BITS_DEFAULT
) (
    input  logic signed [DATA_WIDTH-1:0] sample_i,
    input  logic signed [DATA_WIDTH-1:0] volume_i,
    output logic        [DATA_WIDTH-1:0] result_o,
    output logic                         sat_o
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [63:0] MAX_W = sat_max(DATA_WIDTH);
    localparam logic [63:0] MIN_W = sat_min(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MAX_V = MAX_W[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] MIN_V = MIN_W[DATA_WIDTH-1:0];

    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] v_ext;
    logic signed [PW-1:0] shifted;
    logic                 fits;

    assign s_ext   = {{DATA_WIDTH{sample_i[DATA_WIDTH-1]}}, sample_i};
    assign v_ext   = {{DATA_WIDTH{volume_i[DATA_WIDTH-1]}}, volume_i};
    assign shifted = (s_ext * v_ext) >>> FRAC_BITS;

    // In range iff every bit above the result sign matches the sign.
    assign fits = shifted[PW-1:DATA_WIDTH-1]
               == {(DATA_WIDTH + 1){shifted[PW-1]}};

    assign result_o = fits ? shifted[DATA_WIDTH-1:0]
                    : (shifted[PW-1] ? MIN_V : MAX_V);
    assign sat_o    = ~fits;

endmodule

// File: rtl/audio_gain_stage.sv
// Lock-step multi-channel volume stage between filter and output FIFOs.
// One frame per four cycles: pop, latch, multiply, write.
module audio_gain_stage
    import fm_audio_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int NUM_CH        = 2,
    parameter int FRAC_BITS     = FRAC_BITS_DEFAULT,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_dout,
    input  logic [NUM_CH-1:0]              in_empty,
    output logic [NUM_CH-1:0]              in_rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_din,
    input  logic [NUM_CH-1:0]              out_full,
    output logic [NUM_CH-1:0]              out_wr_en,
    input  logic [DATA_WIDTH-1:0]          volume,
    input  logic                           mute,
    output logic                           frame_done,
    output logic [SAT_CNT_WIDTH-1:0]       sat_count
);

    gain_state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]         vol_q, vol_d;
    logic                          mute_q, mute_d;
    logic [NUM_CH*DATA_WIDTH-1:0]  samp_q, samp_d;
    logic [NUM_CH*DATA_WIDTH-1:0]  res_q, res_d;
    logic [NUM_CH-1:0]             sat_q, sat_d;
    logic [SAT_CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [NUM_CH*DATA_WIDTH-1:0]  mres;
    logic [NUM_CH-1:0]             msat;
    logic [SAT_CNT_WIDTH:0]        sum;
    logic                          go;
    logic                          wr;

    // A frame starts only when every channel can pop and push at once.
    assign go = (state_q == S_WAIT) && !reset
             && ~|in_empty && ~|out_full;
    assign wr = (state_q == S_WRITE) && !reset;

    assign in_rd_en   = {NUM_CH{go}};
    assign out_wr_en  = {NUM_CH{wr}};
    assign frame_done = wr;
    assign out_din    = res_q;
    assign sat_count  = cnt_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gain_sat_mult #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_mult (
            .sample_i(samp_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .volume_i(vol_q),
            .result_o(mres[c*DATA_WIDTH +: DATA_WIDTH]),
            .sat_o   (msat[c])
        );
    end

    always_comb begin
        sum = {1'b0, cnt_q};
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + (SAT_CNT_WIDTH + 1)'(sat_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        mute_d  = mute_q;
        samp_d  = samp_q;
        res_d   = res_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_WAIT: begin
                if (go) begin
                    state_d = S_LATCH;
                    vol_d   = volume;
                    mute_d  = mute;
                end
            end
            S_LATCH: begin
                samp_d  = in_dout;
                state_d = S_MULT;
            end
            S_MULT: begin
                res_d   = mute_q ? '0 : mres;
                sat_d   = mute_q ? '0 : msat;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d   = sum[SAT_CNT_WIDTH] ? '1
                        : sum[SAT_CNT_WIDTH-1:0];
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_WAIT;
            vol_q   <= '0;
            mute_q  <= 1'b0;
            samp_q  <= '0;
            res_q   <= '0;
            sat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            mute_q  <= mute_d;
            samp_q  <= samp_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_audio_gain_stage.sv
// Directed bench for audio_gain_stage with DATA_WIDTH=32, NUM_CH=2.
// Expected outputs are hand-computed Q10 gain results.
module tb_audio_gain_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] in_dout;
    logic [1:0]  in_empty;
    logic [1:0]  in_rd_en;
    logic [63:0] out_din;
    logic [1:0]  out_full;
    logic [1:0]  out_wr_en;
    logic [31:0] volume;
    logic        mute;
    logic        frame_done;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    audio_gain_stage #(
        .DATA_WIDTH   (32),
        .NUM_CH       (2),
        .FRAC_BITS    (10),
        .SAT_CNT_WIDTH(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_din   (out_din),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .volume    (volume),
        .mute      (mute),
        .frame_done(frame_done),
        .sat_count (sat_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs just set; returns in cycle T.
    task automatic wait_rd(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            #1;
            if (in_rd_en == 2'b11) ok = 1'b1;
            else @(negedge clock);
        end
        check({tag, "_start"}, 64'(ok), 64'd1);
    endtask

    task automatic start(input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] vol, input logic m);
        in_dout  = {c1, c0};
        volume   = vol;
        mute     = m;
        in_empty = 2'b00;
        out_full = 2'b00;
    endtask

    // From cycle T: m1 applied at T+1, v2 at T+2, outputs at T+3.
    task automatic finish(input string tag, input logic m1,
                          input logic [31:0] v2, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [15:0] ecnt);
        @(posedge clock); #1;
        in_empty = 2'b11;
        mute     = m1;
        @(negedge clock);
        check({tag, "_t1_wr"}, 64'({in_rd_en, out_wr_en}), 64'd0);
        @(posedge clock); #1;
        volume = v2;
        @(negedge clock);
        check({tag, "_t2_wr"}, 64'({out_wr_en, frame_done}), 64'd0);
        @(negedge clock);
        check({tag, "_t3_wr"}, 64'(out_wr_en), 64'd3);
        check({tag, "_t3_fd"}, 64'(frame_done), 64'd1);
        check({tag, "_ch0"}, 64'(out_din[31:0]), 64'(e0));
        check({tag, "_ch1"}, 64'(out_din[63:32]), 64'(e1));
        @(negedge clock);
        check({tag, "_t4_fd"}, 64'({out_wr_en, frame_done}), 64'd0);
        check({tag, "_sat"}, 64'(sat_count), 64'(ecnt));
    endtask

    initial begin
        int rd_seen;
        reset    = 1'b1;
        in_dout  = '0;
        in_empty = 2'b11;
        out_full = 2'b00;
        volume   = 32'd1024;
        mute     = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_en", 64'({in_rd_en, out_wr_en, frame_done}), 64'd0);
        check("rst_din", out_din, 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);

        start(32'd1000, -32'sd1000, 32'd1024, 1'b0);
        wait_rd("unity");
        finish("unity", 1'b0, 32'd1024, 32'd1000, -32'sd1000, 16'd0);

        start(-32'sd3, 32'd7, 32'd2048, 1'b0);
        wait_rd("x2");
        finish("x2", 1'b0, 32'd2048, -32'sd6, 32'd14, 16'd0);

        start(32'd9, -32'sd3, 32'd512, 1'b0);
        wait_rd("half");
        finish("half", 1'b0, 32'd512, 32'd4, -32'sd2, 16'd0);

        start(32'h4000_0000, 32'd1, 32'd4096, 1'b0);
        wait_rd("satp");
        finish("satp", 1'b0, 32'd4096, 32'h7FFF_FFFF, 32'd4, 16'd1);

        start(32'd5, 32'h8000_0000, -32'sd1024, 1'b0);
        wait_rd("minneg");
        finish("minneg", 1'b0, -32'sd1024, -32'sd5, 32'h7FFF_FFFF, 16'd2);

        start(32'h4000_0000, 32'd0, -32'sd4096, 1'b0);
        wait_rd("satn");
        finish("satn", 1'b0, -32'sd4096, 32'h8000_0000, 32'd0, 16'd3);

        start(32'd1234, -32'sd5, 32'd0, 1'b0);
        wait_rd("vol0");
        finish("vol0", 1'b0, 32'd0, 32'd0, 32'd0, 16'd3);

        start(32'd11, 32'd22, 32'd1024, 1'b0);
        in_empty = 2'b10;
        rd_seen  = 0;
        repeat (20) begin
            @(negedge clock);
            if (in_rd_en != 2'b00) rd_seen++;
        end
        check("flow_empty", 64'(rd_seen), 64'd0);
        in_empty = 2'b00;
        out_full = 2'b01;
        rd_seen  = 0;
        repeat (20) begin
            @(negedge clock);
            if (in_rd_en != 2'b00) rd_seen++;
        end
        check("flow_full", 64'(rd_seen), 64'd0);
        out_full = 2'b00;
        wait_rd("flow");
        finish("flow", 1'b0, 32'd1024, 32'd11, 32'd22, 16'd3);

        start(32'd5000, 32'd77, 32'd1024, 1'b1);
        wait_rd("mute");
        finish("mute", 1'b0, 32'd4096, 32'd0, 32'd0, 16'd3);

        start(32'd5000, 32'd77, 32'd4096, 1'b0);
        wait_rd("post");
        finish("post", 1'b0, 32'd4096, 32'd20000, 32'd308, 16'd3);

        start(32'd99, 32'd98, 32'd1024, 1'b0);
        wait_rd("rstmid");
        @(posedge clock); #1;
        in_empty = 2'b11;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_en", 64'({in_rd_en, out_wr_en, frame_done}), 64'd0);
        check("rstmid_din", out_din, 64'd0);
        check("rstmid_sat", 64'(sat_count), 64'd0);

        start(-32'sd7, 32'd123, 32'd1024, 1'b0);
        wait_rd("after");
        finish("after", 1'b0, 32'd1024, -32'sd7, 32'd123, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
